// File: rtl/v_unit_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : v_unit_pkg
//  Description : Shared constants for the parametrised SIMD vector unit:
//                opcode encodings, default geometry and sizing helpers.
//  Revision    : 1.0  initial release
// ============================================================================
package v_unit_pkg;

    localparam int c_LANES_DEF  = 4;
    localparam int c_LANE_W_DEF = 16;
    localparam int c_NREGS_DEF  = 32;

    // Function-select encodings; 12..31 produce an all-zero result
    localparam logic [4:0] c_FS_PASS  = 5'd0;
    localparam logic [4:0] c_FS_ADD   = 5'd1;
    localparam logic [4:0] c_FS_SUB   = 5'd2;
    localparam logic [4:0] c_FS_AND   = 5'd3;
    localparam logic [4:0] c_FS_OR    = 5'd4;
    localparam logic [4:0] c_FS_XOR   = 5'd5;
    localparam logic [4:0] c_FS_MINU  = 5'd6;
    localparam logic [4:0] c_FS_MAXU  = 5'd7;
    localparam logic [4:0] c_FS_SEL   = 5'd8;
    localparam logic [4:0] c_FS_MAC   = 5'd9;
    localparam logic [4:0] c_FS_LDW   = 5'd10;
    localparam logic [4:0] c_FS_SPLAT = 5'd11;

    // Number of 32-bit words in one vector register
    function automatic int calc_nw(input int lanes, input int lane_w);
        return (lanes * lane_w) / 32;
    endfunction

    // Index width for n items, never narrower than one bit
    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/v_regfile_param.sv
`default_nettype none
// ============================================================================
//  Module      : v_regfile_param
//  Description : NREGS x VW vector register file, three combinational read
//                ports and one synchronous write port; all entries cleared by
//                the asynchronous reset.
//  Ports       : clk, rst           clock / async active-high reset
//                i_we, i_waddr,     write enable, address, data
//                i_wdata
//                i_raddr_{s,t,c}    read addresses
//                o_rdata_{s,t,c}    read data (combinational)
//  Revision    : 1.0  initial release
// ============================================================================
module v_regfile_param
    import v_unit_pkg::*;
#(
    parameter int  NREGS = c_NREGS_DEF,
    parameter int  VW    = 64,
    localparam int AW    = clog2_min1(NREGS)
)(
    input  logic          clk,
    input  logic          rst,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [VW-1:0] i_wdata,
    input  logic [AW-1:0] i_raddr_s,
    input  logic [AW-1:0] i_raddr_t,
    input  logic [AW-1:0] i_raddr_c,
    output logic [VW-1:0] o_rdata_s,
    output logic [VW-1:0] o_rdata_t,
    output logic [VW-1:0] o_rdata_c
);

    logic [VW-1:0] r_mem [NREGS];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata_s = r_mem[i_raddr_s];
    assign o_rdata_t = r_mem[i_raddr_t];
    assign o_rdata_c = r_mem[i_raddr_c];

endmodule
`default_nettype wire

// File: rtl/v_unit_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : v_unit_pipe
//  Description : Pipelined SIMD vector unit. One instruction per cycle via
//                issue_valid/issue_ready, operand stage (OP) then execute
//                stage (EX, Y_reg) then register-file write-back. A consumer
//                of the instruction sitting in OP is held one cycle; a
//                consumer of the instruction in EX/write-back is bypassed.
//  Ports       : clk, reset                 clock / async active-high reset
//                issue_valid, issue_ready   instruction handshake
//                FS                         opcode
//                S/T/C_Addrs, D_Addrs, D_En source / destination registers
//                GPR_DATA, word_sel         scalar word and index for LDW
//                Y_sel, Y_out               32-bit readback of Y_reg
//                y_valid                    Y_reg holds a fresh result
//  Revision    : 1.0  initial release
// ============================================================================
module v_unit_pipe
    import v_unit_pkg::*;
#(
    parameter int  LANES  = c_LANES_DEF,
    parameter int  LANE_W = c_LANE_W_DEF,
    parameter int  NREGS  = c_NREGS_DEF,
    localparam int VW     = LANES * LANE_W,
    localparam int NW     = calc_nw(LANES, LANE_W),
    localparam int AW     = clog2_min1(NREGS),
    localparam int SW     = clog2_min1(NW)
)(
    input  logic          clk,
    input  logic          reset,
    input  logic          issue_valid,
    output logic          issue_ready,
    input  logic [4:0]    FS,
    input  logic [AW-1:0] S_Addrs,
    input  logic [AW-1:0] T_Addrs,
    input  logic [AW-1:0] C_Addrs,
    input  logic [AW-1:0] D_Addrs,
    input  logic          D_En,
    input  logic [31:0]   GPR_DATA,
    input  logic [SW-1:0] word_sel,
    input  logic [SW-1:0] Y_sel,
    output logic [31:0]   Y_out,
    output logic          y_valid
);

    logic          w_accept;
    logic [VW-1:0] w_rf_s, w_rf_t, w_rf_c;
    logic [VW-1:0] w_opnd_s, w_opnd_t, w_opnd_c;
    logic [VW-1:0] w_ldw, w_res;

    // OP stage
    logic          r_op_valid;
    logic          r_op_den;
    logic [4:0]    r_op_fs;
    logic [AW-1:0] r_op_daddr;
    logic [SW-1:0] r_op_word;
    logic [31:0]   r_op_gpr;
    logic [VW-1:0] r_s, r_t, r_c;

    // EX stage
    logic [VW-1:0] r_y;
    logic          r_y_valid;
    logic [AW-1:0] r_wb_addr;
    logic          r_wb_en;

    // The OP-stage result is not yet available anywhere, so any reader of its
    // destination waits one cycle and then picks it up from the EX bypass.
    assign issue_ready = !(r_op_valid && r_op_den &&
                           ((r_op_daddr == S_Addrs) ||
                            (r_op_daddr == T_Addrs) ||
                            (r_op_daddr == C_Addrs)));
    assign w_accept = issue_valid && issue_ready;

    v_regfile_param #(
        .NREGS (NREGS),
        .VW    (VW)
    ) u_regfile (
        .clk       (clk),
        .rst       (reset),
        .i_we      (r_wb_en),
        .i_waddr   (r_wb_addr),
        .i_wdata   (r_y),
        .i_raddr_s (S_Addrs),
        .i_raddr_t (T_Addrs),
        .i_raddr_c (C_Addrs),
        .o_rdata_s (w_rf_s),
        .o_rdata_t (w_rf_t),
        .o_rdata_c (w_rf_c)
    );

    // Y_reg is written to the regfile on the same edge that latches new
    // operands, so the regfile still holds the stale value here.
    assign w_opnd_s = (r_wb_en && (r_wb_addr == S_Addrs)) ? r_y : w_rf_s;
    assign w_opnd_t = (r_wb_en && (r_wb_addr == T_Addrs)) ? r_y : w_rf_t;
    assign w_opnd_c = (r_wb_en && (r_wb_addr == C_Addrs)) ? r_y : w_rf_c;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_op_valid <= 1'b0;
            r_op_den   <= 1'b0;
            r_op_fs    <= '0;
            r_op_daddr <= '0;
            r_op_word  <= '0;
            r_op_gpr   <= '0;
            r_s        <= '0;
            r_t        <= '0;
            r_c        <= '0;
        end else begin
            r_op_valid <= w_accept;
            if (w_accept) begin
                r_op_den   <= D_En;
                r_op_fs    <= FS;
                r_op_daddr <= D_Addrs;
                r_op_word  <= word_sel;
                r_op_gpr   <= GPR_DATA;
                r_s        <= w_opnd_s;
                r_t        <= w_opnd_t;
                r_c        <= w_opnd_c;
            end
        end
    end

    // LDW: S with one 32-bit word replaced by the scalar operand
    for (genvar gw = 0; gw < NW; gw++) begin : g_ldw
        assign w_ldw[32*gw +: 32] = (int'(r_op_word) == gw) ? r_op_gpr
                                                            : r_s[32*gw +: 32];
    end

    for (genvar gl = 0; gl < LANES; gl++) begin : g_lane
        logic [LANE_W-1:0] w_ls, w_lt, w_lc, w_lr;

        assign w_ls = r_s[gl*LANE_W +: LANE_W];
        assign w_lt = r_t[gl*LANE_W +: LANE_W];
        assign w_lc = r_c[gl*LANE_W +: LANE_W];

        always_comb begin
            w_lr = '0;
            case (r_op_fs)
                c_FS_PASS:  w_lr = w_ls;
                c_FS_ADD:   w_lr = w_ls + w_lt;
                c_FS_SUB:   w_lr = w_ls - w_lt;
                c_FS_AND:   w_lr = w_ls & w_lt;
                c_FS_OR:    w_lr = w_ls | w_lt;
                c_FS_XOR:   w_lr = w_ls ^ w_lt;
                c_FS_MINU:  w_lr = (w_ls < w_lt) ? w_ls : w_lt;
                c_FS_MAXU:  w_lr = (w_ls > w_lt) ? w_ls : w_lt;
                c_FS_SEL:   w_lr = (w_lc != '0) ? w_ls : w_lt;
                c_FS_MAC:   w_lr = w_ls * w_lt + w_lc;
                c_FS_LDW:   w_lr = w_ldw[gl*LANE_W +: LANE_W];
                c_FS_SPLAT: w_lr = r_s[LANE_W-1:0];
                default:    w_lr = '0;
            endcase
        end

        assign w_res[gl*LANE_W +: LANE_W] = w_lr;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_y       <= '0;
            r_y_valid <= 1'b0;
            r_wb_addr <= '0;
            r_wb_en   <= 1'b0;
        end else begin
            r_y_valid <= r_op_valid;
            r_wb_en   <= r_op_valid && r_op_den;
            if (r_op_valid) begin
                r_y       <= w_res;
                r_wb_addr <= r_op_daddr;
            end
        end
    end

    assign y_valid = r_y_valid;

    always_comb begin
        Y_out = '0;
        for (int w = 0; w < NW; w++) begin
            if (int'(Y_sel) == w) begin
                Y_out = r_y[32*w +: 32];
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_v_unit_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : tb_v_unit_pipe
//  Description : Self-checking bench for v_unit_pipe. Each accepted
//                instruction is evaluated on a reference model and its
//                result queued; retired results are popped and compared.
//                A second instance exercises the LANES=8 geometry.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_v_unit_pipe;

    localparam logic [4:0] OP_PASS = 5'd0,  OP_ADD = 5'd1,  OP_SUB = 5'd2;
    localparam logic [4:0] OP_SEL  = 5'd8,  OP_MAC = 5'd9,  OP_LDW = 5'd10;
    localparam logic [4:0] OP_SPLAT = 5'd11;

    logic        clk = 1'b0;
    logic        reset;
    logic        issue_valid, issue_ready;
    logic [4:0]  FS, S_Addrs, T_Addrs, C_Addrs, D_Addrs;
    logic        D_En;
    logic [31:0] GPR_DATA, Y_out;
    logic [0:0]  word_sel, Y_sel;
    logic        y_valid;

    logic        s8_issue_valid, s8_issue_ready;
    logic [4:0]  s8_FS, s8_S_Addrs, s8_T_Addrs, s8_C_Addrs, s8_D_Addrs;
    logic        s8_D_En;
    logic [31:0] s8_GPR_DATA, s8_Y_out;
    logic [1:0]  s8_word_sel, s8_Y_sel;
    logic        s8_y_valid;

    always #5 clk = ~clk;

    v_unit_pipe dut (
        .clk(clk), .reset(reset), .issue_valid(issue_valid), .issue_ready(issue_ready),
        .FS(FS), .S_Addrs(S_Addrs), .T_Addrs(T_Addrs), .C_Addrs(C_Addrs),
        .D_Addrs(D_Addrs), .D_En(D_En), .GPR_DATA(GPR_DATA), .word_sel(word_sel),
        .Y_sel(Y_sel), .Y_out(Y_out), .y_valid(y_valid)
    );

    v_unit_pipe #(.LANES(8), .LANE_W(16), .NREGS(32)) dut8 (
        .clk(clk), .reset(reset), .issue_valid(s8_issue_valid), .issue_ready(s8_issue_ready),
        .FS(s8_FS), .S_Addrs(s8_S_Addrs), .T_Addrs(s8_T_Addrs), .C_Addrs(s8_C_Addrs),
        .D_Addrs(s8_D_Addrs), .D_En(s8_D_En), .GPR_DATA(s8_GPR_DATA), .word_sel(s8_word_sel),
        .Y_sel(s8_Y_sel), .Y_out(s8_Y_out), .y_valid(s8_y_valid)
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [63:0] sb_q[$];
    logic [63:0] m_rf[32];
    logic [63:0] last_y;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] model(input logic [4:0] fs, input logic [63:0] s,
                                          input logic [63:0] t, input logic [63:0] c,
                                          input logic [31:0] g, input logic ws);
        logic [63:0] r;
        logic [15:0] a, b, cc, x;
        r = '0;
        for (int i = 0; i < 4; i++) begin
            a  = s[16*i +: 16];
            b  = t[16*i +: 16];
            cc = c[16*i +: 16];
            case (fs)
                5'd0:    x = a;
                5'd1:    x = a + b;
                5'd2:    x = a - b;
                5'd3:    x = a & b;
                5'd4:    x = a | b;
                5'd5:    x = a ^ b;
                5'd6:    x = (a < b) ? a : b;
                5'd7:    x = (a > b) ? a : b;
                5'd8:    x = (cc != 16'd0) ? a : b;
                5'd9:    x = a * b + cc;
                default: x = 16'd0;
            endcase
            r[16*i +: 16] = x;
        end
        if (fs == OP_LDW) begin
            r = s;
            if (ws) r[63:32] = g;
            else    r[31:0]  = g;
        end
        if (fs == OP_SPLAT) r = {4{s[15:0]}};
        return r;
    endfunction

    // Retirement monitor: reads both words of Y_reg and compares to the queue
    initial begin
        logic [63:0] obs, expv;
        Y_sel = 1'b0;
        forever begin
            @(negedge clk);
            if (y_valid === 1'b1) begin
                Y_sel = 1'b0; #1; obs[31:0]  = Y_out;
                Y_sel = 1'b1; #1; obs[63:32] = Y_out;
                Y_sel = 1'b0;
                check_eq("sb_nonempty", 64'(sb_q.size() != 0), 64'd1);
                if (sb_q.size() != 0) begin
                    expv = sb_q.pop_front();
                    check_eq("sb_result", obs, expv);
                end
                last_y = obs;
            end
        end
    end

    task automatic issue(input logic [4:0] fs, input logic [4:0] sa, input logic [4:0] ta,
                         input logic [4:0] ca, input logic [4:0] da, input logic den,
                         input logic [31:0] g, input logic ws, output int stalls);
        logic [63:0] e;
        bit done;
        FS = fs; S_Addrs = sa; T_Addrs = ta; C_Addrs = ca; D_Addrs = da;
        D_En = den; GPR_DATA = g; word_sel = ws; issue_valid = 1'b1;
        stalls = 0; done = 0;
        for (int k = 0; k < 20 && !done; k++) begin
            @(negedge clk);
            if (issue_ready) begin
                e = model(fs, m_rf[sa], m_rf[ta], m_rf[ca], g, ws);
                if (den) m_rf[da] = e;
                sb_q.push_back(e);
                done = 1;
            end else begin
                stalls++;
            end
            @(posedge clk); #1;
        end
        issue_valid = 1'b0;
        if (!done) check_eq("issue_timeout", 64'd0, 64'd1);
    endtask

    task automatic load64(input logic [4:0] r, input logic [63:0] v);
        int st;
        issue(OP_LDW, 5'd0, 5'd0, 5'd0, r, 1'b1, v[31:0], 1'b0, st);
        issue(OP_LDW, r, 5'd0, 5'd0, r, 1'b1, v[63:32], 1'b1, st);
    endtask

    task automatic drain();
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int st;
        reset = 1'b1; issue_valid = 1'b0;
        FS = '0; S_Addrs = '0; T_Addrs = '0; C_Addrs = '0; D_Addrs = '0;
        D_En = 1'b0; GPR_DATA = '0; word_sel = '0;
        s8_issue_valid = 1'b0; s8_FS = '0; s8_S_Addrs = '0; s8_T_Addrs = '0;
        s8_C_Addrs = '0; s8_D_Addrs = '0; s8_D_En = 1'b0; s8_GPR_DATA = '0;
        s8_word_sel = '0; s8_Y_sel = '0;
        for (int i = 0; i < 32; i++) m_rf[i] = '0;
        last_y = '0;

        repeat (2) @(posedge clk); #1;
        check_eq("rst_ready",   64'(issue_ready), 64'd1);
        check_eq("rst_y_valid", 64'(y_valid),     64'd0);
        check_eq("rst_y_out",   64'(Y_out),       64'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        // Independent stream; ADD reads r1 from the regfile and r2 via bypass
        issue(OP_LDW,  5'd0, 5'd0, 5'd0, 5'd1, 1'b1, 32'h0005_0003, 1'b0, st);
        issue(OP_LDW,  5'd0, 5'd0, 5'd0, 5'd2, 1'b1, 32'h0002_0004, 1'b0, st);
        check_eq("ldw_no_stall", 64'(st), 64'd0);
        issue(OP_PASS, 5'd0, 5'd0, 5'd0, 5'd9, 1'b1, 32'd0, 1'b0, st);
        issue(OP_ADD,  5'd1, 5'd2, 5'd0, 5'd3, 1'b1, 32'd0, 1'b0, st);
        check_eq("add_bypass_stall", 64'(st), 64'd0);
        drain();
        check_eq("add_bypass_val", last_y, 64'h0000_0000_0007_0007);

        // Back-to-back dependency: exactly one bubble
        issue(OP_ADD, 5'd1, 5'd1, 5'd0, 5'd3, 1'b1, 32'd0, 1'b0, st);
        issue(OP_SUB, 5'd3, 5'd2, 5'd0, 5'd4, 1'b1, 32'd0, 1'b0, st);
        check_eq("dep_stall", 64'(st), 64'd1);
        drain();
        check_eq("dep_val", last_y, 64'h0000_0000_0008_0002);

        // Lane wrap without carry into the neighbour lane
        load64(5'd10, 64'hFFFF_FFFF_FFFF_FFFF);
        load64(5'd11, 64'h0002_0002_0002_0002);
        issue(OP_ADD, 5'd10, 5'd11, 5'd0, 5'd12, 1'b1, 32'd0, 1'b0, st);
        drain();
        check_eq("lane_wrap", last_y, 64'h0001_0001_0001_0001);

        // SEL and MAC
        load64(5'd13, 64'h0000_FFFF_0000_FFFF);
        load64(5'd14, 64'h1111_1111_1111_1111);
        load64(5'd15, 64'h2222_2222_2222_2222);
        issue(OP_SEL, 5'd14, 5'd15, 5'd13, 5'd16, 1'b1, 32'd0, 1'b0, st);
        drain();
        check_eq("sel", last_y, 64'h2222_1111_2222_1111);
        load64(5'd17, 64'h0003_0003_0003_0003);
        load64(5'd18, 64'h0004_0004_0004_0004);
        load64(5'd19, 64'h0005_0005_0005_0005);
        issue(OP_MAC, 5'd17, 5'd18, 5'd19, 5'd20, 1'b1, 32'd0, 1'b0, st);
        drain();
        check_eq("mac", last_y, 64'h0011_0011_0011_0011);

        // D_En=0 leaves the destination untouched; undefined opcode yields 0
        issue(OP_ADD, 5'd1, 5'd1, 5'd0, 5'd5, 1'b0, 32'd0, 1'b0, st);
        issue(OP_PASS, 5'd5, 5'd0, 5'd0, 5'd0, 1'b0, 32'd0, 1'b0, st);
        drain();
        check_eq("den0_nowrite", last_y, 64'd0);
        issue(5'd20, 5'd14, 5'd15, 5'd0, 5'd21, 1'b1, 32'd0, 1'b0, st);
        drain();
        check_eq("undef_op", last_y, 64'd0);
        issue(OP_SPLAT, 5'd1, 5'd0, 5'd0, 5'd0, 1'b0, 32'd0, 1'b0, st);
        drain();
        check_eq("splat", last_y, 64'h0003_0003_0003_0003);

        // Mixed stream against the model, destinations kept clear of r1..r21
        for (int i = 0; i < 24; i++) begin
            issue(5'($urandom_range(0, 13)), 5'($urandom_range(0, 29)),
                  5'($urandom_range(0, 29)), 5'($urandom_range(0, 29)),
                  5'($urandom_range(22, 29)), 1'($urandom_range(0, 1)),
                  $urandom, 1'($urandom_range(0, 1)), st);
        end
        drain();
        check_eq("sb_drained", 64'(sb_q.size()), 64'd0);

        // Reset with a result in EX and an LDW sitting in OP
        issue(OP_PASS, 5'd17, 5'd0, 5'd0, 5'd30, 1'b0, 32'd0, 1'b0, st);
        issue(OP_LDW, 5'd0, 5'd0, 5'd0, 5'd7, 1'b1, 32'h1234_5678, 1'b0, st);
        reset = 1'b1;
        #1;
        check_eq("midrst_y_valid", 64'(y_valid),     64'd0);
        check_eq("midrst_y_out",   64'(Y_out),       64'd0);
        check_eq("midrst_ready",   64'(issue_ready), 64'd1);
        @(posedge clk); #1;
        reset = 1'b0;
        sb_q.delete();
        for (int i = 0; i < 32; i++) m_rf[i] = '0;
        @(posedge clk); #1;
        last_y = 64'hFFFF_FFFF_FFFF_FFFF;
        issue(OP_PASS, 5'd7, 5'd0, 5'd0, 5'd8, 1'b0, 32'd0, 1'b0, st);
        drain();
        check_eq("midrst_target", last_y, 64'd0);

        // LANES=8 geometry: four words, LDW into the top word
        s8_FS = OP_LDW; s8_D_Addrs = 5'd1; s8_D_En = 1'b1;
        s8_GPR_DATA = 32'hDEAD_BEEF; s8_word_sel = 2'd3; s8_issue_valid = 1'b1;
        #1;
        check_eq("s8_ready", 64'(s8_issue_ready), 64'd1);
        @(posedge clk); #1;
        s8_issue_valid = 1'b0;
        @(posedge clk); #1;
        check_eq("s8_y_valid", 64'(s8_y_valid), 64'd1);
        for (int w = 0; w < 4; w++) begin
            s8_Y_sel = 2'(w);
            #1;
            check_eq("s8_word", 64'(s8_Y_out), (w == 3) ? 64'hDEAD_BEEF : 64'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
